// File: rtl/seq_alu_pkg.sv
// Shared opcode, state and flag-index definitions for the sequential ALU.
// SEQ_ALU_DIV_EN (optional build macro) enables the iterative divider in seq_alu.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_ORR  = 4'b0011;
    localparam logic [3:0] OP_ADC  = 4'b0100;
    localparam logic [3:0] OP_EOR  = 4'b0101;
    localparam logic [3:0] OP_BIC  = 4'b0110;
    localparam logic [3:0] OP_MVN  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_RSB  = 4'b1001;
    localparam logic [3:0] OP_RSC  = 4'b1010;
    localparam logic [3:0] OP_SBC  = 4'b1011;
    localparam logic [3:0] OP_MULS = 4'b1100;
    localparam logic [3:0] OP_MOV  = 4'b1101;
    localparam logic [3:0] OP_DIVU = 4'b1110;
    localparam logic [3:0] OP_DIVS = 4'b1111;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic is_mul(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_MULS);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_DIVS);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == OP_MULS) || (op == OP_DIVS);
    endfunction

endpackage

// File: rtl/seq_alu_div.sv
// Restoring shift-subtract divider on unsigned magnitudes, one quotient bit per step.
// Only instantiated when SEQ_ALU_DIV_EN is defined.
module seq_alu_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo_next,
    output logic [WIDTH-1:0] rem_next
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic             fits;

    // The step outputs are exposed so the caller can capture the final step directly.
    always_comb begin
        r_shift  = {r_reg, q_reg[WIDTH-1]};
        diff     = r_shift - {1'b0, d_reg};
        fits     = ~diff[WIDTH];
        quo_next = {q_reg[WIDTH-2:0], fits};
        rem_next = fits ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= '0;
            r_reg <= '0;
            d_reg <= '0;
        end else if (load) begin
            q_reg <= dividend;
            r_reg <= '0;
            d_reg <= divisor;
        end else if (step) begin
            q_reg <= quo_next;
            r_reg <= rem_next;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic, WIDTH-cycle shift-add multiply and,
// with SEQ_ALU_DIV_EN defined, WIDTH-cycle divide. Results are held until the next accepted Start.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [3:0]       ALUControl,
    input  logic             Carry,
    input  logic [WIDTH-1:0] Src_A,
    input  logic [WIDTH-1:0] Src_B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic [3:0]       ALUFlags
);

    localparam int CW = $clog2(WIDTH);

    state_t             state_reg;
    logic [CW-1:0]      cnt_reg;
    logic [3:0]         op_reg;
    logic [WIDTH-1:0]   mcand_reg;
    logic [2*WIDTH-1:0] prod_reg;
    logic               neg_reg;
    logic [WIDTH-1:0]   result1_reg;
    logic [WIDTH-1:0]   result2_reg;
    logic [3:0]         flags_reg;

    logic               start_multi;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH-1:0]   add_x;
    logic [WIDTH-1:0]   add_y;
    logic               add_cin;
    logic               arith;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   sc_r1;
    logic [3:0]         sc_flags;

    logic [WIDTH:0]     hi_sum;
    logic [2*WIDTH-1:0] prod_next;
    logic [2*WIDTH-1:0] prod_final;
    logic [WIDTH-1:0]   mc_r1;
    logic [WIDTH-1:0]   mc_r2;
    logic [3:0]         mc_flags;

    assign Busy     = (state_reg == ST_CALC);
    assign Done     = (state_reg == ST_DONE);
    assign Result1  = result1_reg;
    assign Result2  = result2_reg;
    assign ALUFlags = flags_reg;

    assign a_neg = is_signed_op(ALUControl) & Src_A[WIDTH-1];
    assign b_neg = is_signed_op(ALUControl) & Src_B[WIDTH-1];
    assign a_mag = a_neg ? -Src_A : Src_A;
    assign b_mag = b_neg ? -Src_B : Src_B;

`ifdef SEQ_ALU_DIV_EN
    logic               rem_neg_reg;
    logic               div0_reg;
    logic [WIDTH-1:0]   a_orig_reg;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   rem_next;
    logic               div_load;
    logic               div_step;

    assign start_multi = is_mul(ALUControl) | is_div(ALUControl);
    assign div_load    = (state_reg == ST_IDLE) & Start & is_div(ALUControl);
    assign div_step    = (state_reg == ST_CALC) & is_div(op_reg);

    seq_alu_div #(.WIDTH(WIDTH)) u_div (
        .clk      (CLK),
        .rst      (RESET),
        .load     (div_load),
        .step     (div_step),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quo_next (quo_next),
        .rem_next (rem_next)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rem_neg_reg <= 1'b0;
            div0_reg    <= 1'b0;
            a_orig_reg  <= '0;
        end else if ((state_reg == ST_IDLE) && Start) begin
            rem_neg_reg <= a_neg;
            div0_reg    <= (Src_B == '0);
            a_orig_reg  <= Src_A;
        end
    end
`else
    assign start_multi = is_mul(ALUControl);
`endif

    // One adder serves every add-type op; subtracts feed the inverted operand.
    always_comb begin
        add_x   = Src_A;
        add_y   = Src_B;
        add_cin = 1'b0;
        arith   = 1'b1;
        case (ALUControl)
            OP_ADD: ;
            OP_SUB: begin add_y = ~Src_B; add_cin = 1'b1; end
            OP_ADC: add_cin = Carry;
            OP_SBC: begin add_y = ~Src_B; add_cin = Carry; end
            OP_RSB: begin add_x = Src_B; add_y = ~Src_A; add_cin = 1'b1; end
            OP_RSC: begin add_x = Src_B; add_y = ~Src_A; add_cin = Carry; end
            default: arith = 1'b0;
        endcase
        sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};

        case (ALUControl)
            OP_AND:  sc_r1 = Src_A & Src_B;
            OP_ORR:  sc_r1 = Src_A | Src_B;
            OP_EOR:  sc_r1 = Src_A ^ Src_B;
            OP_BIC:  sc_r1 = Src_A & ~Src_B;
            OP_MVN:  sc_r1 = ~Src_B;
            default: sc_r1 = arith ? sum[WIDTH-1:0] : Src_B;
        endcase

        sc_flags         = '0;
        sc_flags[FLAG_N] = sc_r1[WIDTH-1];
        sc_flags[FLAG_Z] = (sc_r1 == '0);
        sc_flags[FLAG_C] = arith & sum[WIDTH];
        sc_flags[FLAG_V] = arith & (add_x[WIDTH-1] == add_y[WIDTH-1])
                                 & (sum[WIDTH-1] != add_x[WIDTH-1]);
`ifndef SEQ_ALU_DIV_EN
        if (is_div(ALUControl)) begin
            sc_r1    = '0;
            sc_flags = 4'b0101;
        end
`endif
    end

    // Shift-add multiply step on magnitudes; sign is restored on the full product.
    always_comb begin
        hi_sum     = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
                   + (prod_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
        prod_next  = {hi_sum, prod_reg[WIDTH-1:1]};
        prod_final = neg_reg ? -prod_next : prod_next;

        mc_r1            = prod_final[WIDTH-1:0];
        mc_r2            = prod_final[2*WIDTH-1:WIDTH];
        mc_flags         = '0;
        mc_flags[FLAG_N] = mc_r2[WIDTH-1];
        mc_flags[FLAG_Z] = (prod_final == '0);
`ifdef SEQ_ALU_DIV_EN
        if (is_div(op_reg)) begin
            if (div0_reg) begin
                mc_r1 = '1;
                mc_r2 = a_orig_reg;
            end else begin
                mc_r1 = neg_reg ? -quo_next : quo_next;
                mc_r2 = rem_neg_reg ? -rem_next : rem_next;
            end
            mc_flags         = '0;
            mc_flags[FLAG_N] = mc_r1[WIDTH-1];
            mc_flags[FLAG_Z] = (mc_r1 == '0);
            mc_flags[FLAG_V] = div0_reg;
        end
`endif
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            op_reg      <= '0;
            mcand_reg   <= '0;
            prod_reg    <= '0;
            neg_reg     <= 1'b0;
            result1_reg <= '0;
            result2_reg <= '0;
            flags_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: if (Start) begin
                    op_reg    <= ALUControl;
                    mcand_reg <= a_mag;
                    prod_reg  <= {{WIDTH{1'b0}}, b_mag};
                    neg_reg   <= a_neg ^ b_neg;
                    cnt_reg   <= '0;
                    if (start_multi) begin
                        state_reg <= ST_CALC;
                    end else begin
                        state_reg   <= ST_DONE;
                        result1_reg <= sc_r1;
                        result2_reg <= '0;
                        flags_reg   <= sc_flags;
                    end
                end
                ST_CALC: begin
                    prod_reg <= prod_next;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(WIDTH-1)) begin
                        state_reg   <= ST_DONE;
                        result1_reg <= mc_r1;
                        result2_reg <= mc_r2;
                        flags_reg   <= mc_flags;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu (WIDTH=32); divider expectations follow SEQ_ALU_DIV_EN.
module tb_seq_alu;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        Start;
    logic [3:0]  ALUControl;
    logic        Carry;
    logic [31:0] Src_A;
    logic [31:0] Src_B;
    logic        Busy;
    logic        Done;
    logic [31:0] Result1;
    logic [31:0] Result2;
    logic [3:0]  ALUFlags;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(32)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .Start      (Start),
        .ALUControl (ALUControl),
        .Carry      (Carry),
        .Src_A      (Src_A),
        .Src_B      (Src_B),
        .Busy       (Busy),
        .Done       (Done),
        .Result1    (Result1),
        .Result2    (Result2),
        .ALUFlags   (ALUFlags)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble the inputs after acceptance, wait (bounded) for Done.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic c, output int lat, output int busy_n);
        @(negedge CLK);
        ALUControl = op; Src_A = a; Src_B = b; Carry = c; Start = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0; Src_A = ~a; Src_B = ~b; Carry = ~c; ALUControl = ~op;
        lat = 0;
        busy_n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            lat++;
            if (Busy) busy_n++;
            if (Done) break;
        end
        $display("op=%b a=%h b=%h c=%0d lat=%0d busy=%0d r1=%h r2=%h flags=%b",
                 op, a, b, c, lat, busy_n, Result1, Result2, ALUFlags);
    endtask

    task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic c,
                          input logic [31:0] exp_r1, input logic [3:0] exp_f);
        int lat, busy_n;
        run_op(op, a, b, c, lat, busy_n);
        check({tag, "_lat"}, 64'(lat), 64'd1);
        check({tag, "_r1"}, 64'(Result1), 64'(exp_r1));
        check({tag, "_flags"}, 64'(ALUFlags), 64'(exp_f));
    endtask

    task automatic multi(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r1,
                         input logic [31:0] exp_r2, input logic [3:0] exp_f);
        int lat, busy_n;
        run_op(op, a, b, 1'b0, lat, busy_n);
        check({tag, "_lat"}, 64'(lat), 64'd33);
        check({tag, "_busy"}, 64'(busy_n), 64'd32);
        check({tag, "_r1"}, 64'(Result1), 64'(exp_r1));
        check({tag, "_r2"}, 64'(Result2), 64'(exp_r2));
        check({tag, "_flags"}, 64'(ALUFlags), 64'(exp_f));
    endtask

    initial begin
        int lat, busy_n, dones;
        RESET = 1'b1; Start = 1'b0; ALUControl = 4'b0000; Carry = 1'b0;
        Src_A = '0; Src_B = '0;
        repeat (2) @(negedge CLK);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_r1", 64'(Result1), 64'd0);
        check("rst_r2", 64'(Result2), 64'd0);
        check("rst_flags", 64'(ALUFlags), 64'd0);
        RESET = 1'b0;

        multi("mulu_max", 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 4'b1000);
        single("sub_eq", 4'b0001, 32'h5, 32'h5, 1'b0, 32'h0, 4'b0110);
        check("sub_r2_zero", 64'(Result2), 64'd0);
        single("add_ovf", 4'b0000, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 4'b1001);
        single("and", 4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'h00F000F0, 4'b0000);
        single("orr", 4'b0011, 32'h00000F00, 32'h0000000F, 1'b0, 32'h00000F0F, 4'b0000);
        single("eor", 4'b0101, 32'hFFFF0000, 32'h0F0F0F0F, 1'b0, 32'hF0F00F0F, 4'b1000);
        single("bic", 4'b0110, 32'h000000FF, 32'h0000000F, 1'b0, 32'h000000F0, 4'b0000);
        single("mvn", 4'b0111, 32'h12345678, 32'h0, 1'b0, 32'hFFFFFFFF, 4'b1000);
        single("mov", 4'b1101, 32'h12345678, 32'h0, 1'b0, 32'h0, 4'b0100);
        single("adc", 4'b0100, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 4'b0110);
        single("sbc", 4'b1011, 32'h5, 32'h7, 1'b0, 32'hFFFFFFFD, 4'b1000);
        single("rsb", 4'b1001, 32'h3, 32'hA, 1'b0, 32'h7, 4'b0010);
        single("rsc", 4'b1010, 32'h1, 32'h0, 1'b1, 32'hFFFFFFFF, 4'b1000);
        multi("muls", 4'b1100, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFA, 32'hFFFFFFFF, 4'b1000);

`ifdef SEQ_ALU_DIV_EN
        multi("divs", 4'b1111, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, 4'b1000);
        multi("divu", 4'b1110, 32'd100, 32'd7, 32'd14, 32'd2, 4'b0000);
        multi("divu0", 4'b1110, 32'd100, 32'd0, 32'hFFFFFFFF, 32'd100, 4'b1001);
`else
        single("divs_off", 4'b1111, 32'hFFFFFFF9, 32'h2, 1'b0, 32'h0, 4'b0101);
        check("divs_off_r2", 64'(Result2), 64'd0);
        single("divu_off", 4'b1110, 32'd100, 32'd0, 1'b0, 32'h0, 4'b0101);
`endif

        // Abort a MULU after 10 busy cycles; Start during reset must be ignored.
        @(negedge CLK);
        ALUControl = 4'b1000; Src_A = 32'd1000; Src_B = 32'd1000; Start = 1'b1;
        @(posedge CLK);
        #1 Start = 1'b0;
        repeat (10) @(negedge CLK);
        check("abort_busy_before", 64'(Busy), 64'd1);
        RESET = 1'b1; Start = 1'b1; ALUControl = 4'b0000; Src_A = 32'd1; Src_B = 32'd1;
        #1;
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_r1", 64'(Result1), 64'd0);
        check("abort_r2", 64'(Result2), 64'd0);
        check("abort_flags", 64'(ALUFlags), 64'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0; Start = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (Done || Busy) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        multi("mulu_after_rst", 4'b1000, 32'd6, 32'd7, 32'd42, 32'd0, 4'b0000);

        // Start held high through Busy with changing inputs.
        @(negedge CLK);
        ALUControl = 4'b1000; Src_A = 32'd5; Src_B = 32'd9; Start = 1'b1;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK);
            #1;
            Src_A = $urandom; Src_B = $urandom; ALUControl = 4'($urandom); Carry = 1'($urandom);
            @(negedge CLK);
            lat++;
            if (Done) break;
        end
        $display("op=1000 a=00000005 b=00000009 held_start lat=%0d r1=%h r2=%h flags=%b",
                 lat, Result1, Result2, ALUFlags);
        check("held_lat", 64'(lat), 64'd33);
        check("held_r1", 64'(Result1), 64'd45);
        check("held_r2", 64'(Result2), 64'd0);
        ALUControl = 4'b0000; Src_A = 32'd1; Src_B = 32'd2; Carry = 1'b0;
        @(negedge CLK);
        check("held_gap_done", 64'(Done), 64'd0);
        check("held_gap_busy", 64'(Busy), 64'd0);
        @(negedge CLK);
        Start = 1'b0;
        $display("op=0000 a=00000001 b=00000002 b2b done=%0d r1=%h flags=%b", Done, Result1, ALUFlags);
        check("b2b_done", 64'(Done), 64'd1);
        check("b2b_r1", 64'(Result1), 64'd3);
        Src_A = 32'hDEAD; Src_B = 32'hBEEF;
        repeat (3) @(negedge CLK);
        check("hold_r1", 64'(Result1), 64'd3);
        check("hold_flags", 64'(ALUFlags), 64'd0);
        check("hold_done", 64'(Done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
